usb_ctrl_responder: RTL

USB_CTRL_RESPONDER -- requirements
Module: usb_ctrl_responder

---
 rtl/usb_ctrl_responder_pkg.sv | 46 ++++
 rtl/usb_ctrl_responder_if.sv | 33 +++
 rtl/usb_desc_rom.sv | 46 ++++
 rtl/usb_ctrl_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_responder_pkg.sv
// Shared USB control-transfer codes (requests, descriptor types, token types, handshakes)
// plus the responder's state and setup-packet types.
package usb_ctrl_responder_pkg;

  localparam logic [7:0] REQ_SET_ADDRESS    = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;

  localparam logic [7:0] DESC_DEVICE        = 8'h01;
  localparam logic [7:0] DESC_CONFIGURATION = 8'h02;
  localparam logic [7:0] DESC_STRING        = 8'h03;

  // Token type is one-hot, ordered {SETUP, OUT, IN} from MSB to LSB.
  localparam logic [2:0] TXN_SETUP = 3'b100;
  localparam logic [2:0] TXN_OUT   = 3'b010;
  localparam logic [2:0] TXN_IN    = 3'b001;

  typedef enum logic [1:0] {
    HS_DATA  = 2'd0,
    HS_NAK   = 2'd1,
    HS_STALL = 2'd2
  } hs_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA_IN,
    S_STATUS_OUT,
    S_STATUS_IN,
    S_STALL
  } state_t;

  // Field order mirrors the wire layout: bmRequestType is byte 0 (LSB).
  typedef struct packed {
    logic [15:0] wlength;
    logic [15:0] windex;
    logic [15:0] wvalue;
    logic [7:0]  brequest;
    logic [7:0]  bmrequesttype;
  } setup_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/usb_ctrl_responder_if.sv
// Endpoint-0 packet bus: received tokens in (valid/ready), IN responses out (valid/ready).
// The responder drives the slave side; the packet engine drives the master side.
interface usb_ctrl_responder_if #(
  parameter int MAX_PKT = 8
);
  localparam int NB_W = $clog2(MAX_PKT) + 1;

  logic                 i_rxValid;
  logic                 o_rxReady;
  logic [2:0]           i_rxType;
  logic [8*MAX_PKT-1:0] i_rxData;
  logic [NB_W-1:0]      i_rxData_nBytes;

  logic                 o_txValid;
  logic                 i_txReady;
  logic [8*MAX_PKT-1:0] o_txData;
  logic [NB_W-1:0]      o_txData_nBytes;
  logic [1:0]           o_txHandshake;
  logic                 o_txDataPid;

  logic [6:0]           o_devAddr;

  modport slave (
    input  i_rxValid, i_rxType, i_rxData, i_rxData_nBytes, i_txReady,
    output o_rxReady, o_txValid, o_txData, o_txData_nBytes, o_txHandshake, o_txDataPid, o_devAddr
  );

  modport master (
    output i_rxValid, i_rxType, i_rxData, i_rxData_nBytes, i_txReady,
    input  o_rxReady, o_txValid, o_txData, o_txData_nBytes, o_txHandshake, o_txDataPid, o_devAddr
  );

endinterface

// File: rtl/usb_desc_rom.sv
// Combinational descriptor ROM: MAX_PKT bytes starting at a byte offset, LSB byte first;
// bytes past the end of the selected descriptor read as zero.
module usb_desc_rom
  import usb_ctrl_responder_pkg::*;
#(
  parameter int MAX_PKT      = 8,
  parameter int DEV_DESC_LEN = 18,
  parameter int CFG_DESC_LEN = 32
) (
  input  logic [15:0]          offset,
  input  logic                 sel_cfg,
  output logic [8*MAX_PKT-1:0] bytes
);

  localparam int DEV_N = (DEV_DESC_LEN < 18) ? DEV_DESC_LEN : 18;
  localparam int CFG_N = (CFG_DESC_LEN < 32) ? CFG_DESC_LEN : 32;

  localparam logic [7:0] DEV_ROM [18] = '{
    8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h34,
    8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01
  };

  // Configuration + one vendor interface + bulk IN/OUT endpoints.
  localparam logic [7:0] CFG_ROM [32] = '{
    8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32,
    8'h09, 8'h04, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
    8'h07, 8'h05, 8'h81, 8'h02, 8'h40, 8'h00, 8'h00,
    8'h07, 8'h05, 8'h02, 8'h02, 8'h40, 8'h00, 8'h00
  };

  logic [31:0] idx;

  always_comb begin
    bytes = '0;
    idx   = '0;
    for (int i = 0; i < MAX_PKT; i++) begin
      idx = 32'(offset) + 32'(i);
      if (sel_cfg) begin
        if (idx < 32'(CFG_N)) bytes[8*i +: 8] = CFG_ROM[idx[4:0]];
      end else begin
        if (idx < 32'(DEV_N)) bytes[8*i +: 8] = DEV_ROM[idx[4:0]];
      end
    end
  end

endmodule

// File: rtl/usb_ctrl_responder.sv
// Endpoint-0 control responder (GET_DESCRIPTOR / SET_ADDRESS); IN response 1 cycle after the IN token.
// A pending IN response holds o_txValid/data until i_txReady and blocks o_rxReady meanwhile.
module usb_ctrl_responder
  import usb_ctrl_responder_pkg::*;
#(
  parameter int MAX_PKT      = 8,
  parameter int DEV_DESC_LEN = 18,
  parameter int CFG_DESC_LEN = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  usb_ctrl_responder_if.slave bus
);

  localparam int NB_W = $clog2(MAX_PKT) + 1;

  state_t               state_q, state_n;
  setup_t               setup_q, setup_n;
  logic                 desc_sel_q, desc_sel_n;
  logic [15:0]          offset_q, offset_n;
  logic [15:0]          remaining_q, remaining_n;
  logic                 toggle_q, toggle_n;
  logic [6:0]           pend_addr_q, pend_addr_n;
  logic [6:0]           dev_addr_q, dev_addr_n;
  logic                 tx_valid_q, tx_valid_n;
  logic [8*MAX_PKT-1:0] tx_data_q, tx_data_n;
  logic [NB_W-1:0]      tx_nbytes_q, tx_nbytes_n;
  hs_t                  tx_hs_q, tx_hs_n;
  logic                 tx_pid_q, tx_pid_n;

  logic                 rx_fire, tx_fire, std_req, is_dev, is_cfg;
  setup_t               setup_in;
  logic [NB_W-1:0]      pkt_len;
  logic [8*MAX_PKT-1:0] rom_bytes, pkt_data;
  logic [15:0]          desc_len, sent;
  logic                 unused_bits;

  usb_desc_rom #(
    .MAX_PKT     (MAX_PKT),
    .DEV_DESC_LEN(DEV_DESC_LEN),
    .CFG_DESC_LEN(CFG_DESC_LEN)
  ) u_rom (
    .offset (offset_q),
    .sel_cfg(desc_sel_q),
    .bytes  (rom_bytes)
  );

  assign rx_fire  = bus.i_rxValid && !tx_valid_q;
  assign tx_fire  = tx_valid_q && bus.i_txReady;
  assign setup_in = setup_t'(bus.i_rxData[63:0]);
  assign std_req  = (setup_in.bmrequesttype[6:5] == 2'b00);
  assign is_dev   = (setup_in.wvalue[15:8] == DESC_DEVICE);
  assign is_cfg   = (setup_in.wvalue[15:8] == DESC_CONFIGURATION);
  assign pkt_len  = (remaining_q < 16'(MAX_PKT)) ? remaining_q[NB_W-1:0] : NB_W'(MAX_PKT);
  assign unused_bits = ^{setup_q, setup_in, bus.i_rxData};

  // Bytes beyond the packet length are zeroed so a truncated transfer never leaks descriptor data.
  always_comb begin
    pkt_data = '0;
    for (int i = 0; i < MAX_PKT; i++) begin
      if (NB_W'(i) < pkt_len) pkt_data[8*i +: 8] = rom_bytes[8*i +: 8];
    end
  end

  always_comb begin
    state_n     = state_q;
    setup_n     = setup_q;
    desc_sel_n  = desc_sel_q;
    offset_n    = offset_q;
    remaining_n = remaining_q;
    toggle_n    = toggle_q;
    pend_addr_n = pend_addr_q;
    dev_addr_n  = dev_addr_q;
    tx_valid_n  = tx_valid_q;
    tx_data_n   = tx_data_q;
    tx_nbytes_n = tx_nbytes_q;
    tx_hs_n     = tx_hs_q;
    tx_pid_n    = tx_pid_q;
    desc_len    = 16'(DEV_DESC_LEN);
    sent        = 16'(tx_nbytes_q);

    if (rx_fire && bus.i_rxType == TXN_SETUP && bus.i_rxData_nBytes == NB_W'(8)) begin
      setup_n = setup_in;
      state_n = S_STALL;
      if (std_req && setup_in.brequest == REQ_GET_DESCRIPTOR && (is_dev || is_cfg)) begin
        desc_sel_n  = is_cfg;
        if (is_cfg) desc_len = 16'(CFG_DESC_LEN);
        remaining_n = (setup_in.wlength < desc_len) ? setup_in.wlength : desc_len;
        offset_n    = '0;
        toggle_n    = 1'b1;
        state_n     = S_DATA_IN;
      end else if (std_req && setup_in.brequest == REQ_SET_ADDRESS) begin
        pend_addr_n = setup_in.wvalue[6:0];
        state_n     = S_STATUS_IN;
      end
    end else if (rx_fire && bus.i_rxType == TXN_OUT) begin
      // An OUT during DATA_IN is the host cutting the data stage short.
      if (state_q == S_DATA_IN || (state_q == S_STATUS_OUT && bus.i_rxData_nBytes == '0))
        state_n = S_IDLE;
    end else if (rx_fire && bus.i_rxType == TXN_IN) begin
      tx_valid_n  = 1'b1;
      tx_data_n   = '0;
      tx_nbytes_n = '0;
      tx_pid_n    = 1'b0;
      tx_hs_n     = HS_NAK;
      case (state_q)
        S_DATA_IN: begin
          tx_hs_n     = HS_DATA;
          tx_data_n   = pkt_data;
          tx_nbytes_n = pkt_len;
          tx_pid_n    = toggle_q;
        end
        S_STATUS_IN: begin
          tx_hs_n  = HS_DATA;
          tx_pid_n = 1'b1;
        end
        S_STALL: tx_hs_n = HS_STALL;
        default: tx_hs_n = HS_NAK;
      endcase
    end else if (tx_fire) begin
      tx_valid_n = 1'b0;
      if (state_q == S_DATA_IN) begin
        offset_n    = sat_add16(offset_q, sent);
        remaining_n = (remaining_q > sent) ? remaining_q - sent : '0;
        toggle_n    = ~toggle_q;
        // A full last packet still owes a ZLP unless it exactly satisfied wLength.
        if (remaining_n == '0 && (tx_nbytes_q < NB_W'(MAX_PKT) || offset_n == setup_q.wlength))
          state_n = S_STATUS_OUT;
      end else if (state_q == S_STATUS_IN) begin
        dev_addr_n = pend_addr_q;
        state_n    = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      setup_q     <= '0;
      desc_sel_q  <= 1'b0;
      offset_q    <= '0;
      remaining_q <= '0;
      toggle_q    <= 1'b0;
      pend_addr_q <= '0;
      dev_addr_q  <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_nbytes_q <= '0;
      tx_hs_q     <= HS_DATA;
      tx_pid_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      setup_q     <= setup_n;
      desc_sel_q  <= desc_sel_n;
      offset_q    <= offset_n;
      remaining_q <= remaining_n;
      toggle_q    <= toggle_n;
      pend_addr_q <= pend_addr_n;
      dev_addr_q  <= dev_addr_n;
      tx_valid_q  <= tx_valid_n;
      tx_data_q   <= tx_data_n;
      tx_nbytes_q <= tx_nbytes_n;
      tx_hs_q     <= tx_hs_n;
      tx_pid_q    <= tx_pid_n;
    end
  end

  assign bus.o_rxReady       = !tx_valid_q;
  assign bus.o_txValid       = tx_valid_q;
  assign bus.o_txData        = tx_data_q;
  assign bus.o_txData_nBytes = tx_nbytes_q;
  assign bus.o_txHandshake   = tx_hs_q;
  assign bus.o_txDataPid     = tx_pid_q;
  assign bus.o_devAddr       = dev_addr_q;

endmodule
